// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage in-order pipeline: load-use stalls, branch flushes,
// data-memory wait holds, EX operand forwarding and a retired-instruction counter.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [1:0]  id_use_rs,
    input  logic [4:0]  id_rd,
    input  logic        id_rf_we,
    input  logic        id_is_load,
    input  logic        id_is_mem,
    input  logic        id_num_check,
    input  logic        ex_taken,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_we,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [31:0] num_inst
);

    // Handshake: dmem_ready is sampled in the cycle the MEM-stage access is pending;
    // while it is low the whole pipeline holds and no shadow stage advances.

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_we;
        logic       load;
        logic       mem;
        logic       chk;
    } stage_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_MWAIT    = 2'b11
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    stage_t      ex_q, mem_q, wb_q;
    logic [4:0]  ex_rs1_q, ex_rs2_q;
    logic [1:0]  ex_use_q;
    state_t      state_q, state_d;
    logic [31:0] cnt_q;

    logic mwait, lu_hazard;
    logic a_mem, a_wb, b_mem, b_wb;

    assign mwait     = mem_q.valid & mem_q.mem & ~dmem_ready;
    assign lu_hazard = id_valid & ex_q.valid & ex_q.load & (ex_q.rd != 5'd0) &
                       ((id_use_rs[0] & (id_rs1 == ex_q.rd)) |
                        (id_use_rs[1] & (id_rs2 == ex_q.rd)));

    // Priority: reset, memory wait, flush, load-use stall, run.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_we     = 1'b1;
        state_d     = ST_RUN;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_we     = 1'b1;
            state_d     = ST_RUN;
        end else if (mwait) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_we     = 1'b0;
            state_d     = ST_MWAIT;
        end else if (ex_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_FLUSH;
        end else if (lu_hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_LU_STALL;
        end
    end

    // Forwarding looks only at the shadow stages, so it never depends on dmem_ready.
    assign a_mem = mem_q.valid & mem_q.rf_we & (mem_q.rd != 5'd0) & (mem_q.rd == ex_rs1_q) & ex_use_q[0];
    assign a_wb  = wb_q.valid  & wb_q.rf_we  & (wb_q.rd  != 5'd0) & (wb_q.rd  == ex_rs1_q) & ex_use_q[0];
    assign b_mem = mem_q.valid & mem_q.rf_we & (mem_q.rd != 5'd0) & (mem_q.rd == ex_rs2_q) & ex_use_q[1];
    assign b_wb  = wb_q.valid  & wb_q.rf_we  & (wb_q.rd  != 5'd0) & (wb_q.rd  == ex_rs2_q) & ex_use_q[1];

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            if (a_mem)     fwd_a = FWD_MEM;
            else if (a_wb) fwd_a = FWD_WB;
            if (b_mem)     fwd_b = FWD_MEM;
            else if (b_wb) fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_use_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
        end else begin
            state_q <= state_d;
            if (pipe_we) begin
                if (wb_q.valid & wb_q.chk)
                    cnt_q <= cnt_q + 32'd1;
                wb_q     <= mem_q;
                mem_q    <= ex_q;
                ex_q     <= '{valid: id_valid & ~idex_bubble, rd: id_rd, rf_we: id_rf_we,
                              load: id_is_load, mem: id_is_mem, chk: id_num_check};
                ex_rs1_q <= id_rs1;
                ex_rs2_q <= id_rs2;
                ex_use_q <= id_use_rs;
            end
        end
    end

    assign state    = state_q;
    assign num_inst = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rf_we, id_is_load, id_is_mem, id_num_check;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_use_rs;
    logic        ex_taken, dmem_ready;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [31:0] num_inst;
    logic [4:0]  ctrl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs(id_use_rs), .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
        .id_is_mem(id_is_mem), .id_num_check(id_num_check), .ex_taken(ex_taken),
        .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_we(pipe_we), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state), .num_inst(num_inst)
    );

    assign ctrl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we};

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
        bit       mem;
        bit       chk;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [1:0] use_rs;
    } instr_t;

    instr_t      nop = '{default: '0};
    instr_t      id_cur = '{default: '0};
    instr_t      m_ex = '{default: '0};
    instr_t      m_mem = '{default: '0};
    instr_t      m_wb = '{default: '0};
    logic [31:0] m_cnt = '0;
    logic [1:0]  m_state = 2'b00;
    logic [4:0]  e_ctrl;
    logic [1:0]  e_fwd_a, e_fwd_b, e_cls;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic instr_t mk(input bit v, input bit [4:0] rd, input bit we, input bit ld,
                                  input bit mem, input bit chk, input bit [4:0] rs1,
                                  input bit [4:0] rs2, input bit [1:0] use_rs);
        instr_t i;
        i.v = v; i.rd = rd; i.we = we; i.ld = ld; i.mem = mem; i.chk = chk;
        i.rs1 = rs1; i.rs2 = rs2; i.use_rs = use_rs;
        return i;
    endfunction

    function automatic bit writes(input instr_t s, input bit [4:0] r);
        return s.v && s.we && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] src(input bit [4:0] r, input bit used);
        if (!used)            return 2'b00;
        if (writes(m_mem, r)) return 2'b01;
        if (writes(m_wb, r))  return 2'b10;
        return 2'b00;
    endfunction

    // Expected control for the current inputs, ctrl = {pc_we, ifid_we, flush, bubble, pipe_we}.
    function automatic void model_eval();
        bit hazard;
        hazard = id_cur.v && m_ex.v && m_ex.ld && (m_ex.rd != 5'd0) &&
                 ((id_cur.use_rs[0] && id_cur.rs1 == m_ex.rd) ||
                  (id_cur.use_rs[1] && id_cur.rs2 == m_ex.rd));
        e_fwd_a = src(m_ex.rs1, m_ex.use_rs[0]);
        e_fwd_b = src(m_ex.rs2, m_ex.use_rs[1]);
        if (rst) begin
            e_ctrl = 5'b00111; e_cls = 2'b00; e_fwd_a = 2'b00; e_fwd_b = 2'b00;
        end else if (m_mem.v && m_mem.mem && !dmem_ready) begin
            e_ctrl = 5'b00000; e_cls = 2'b11;
        end else if (ex_taken) begin
            e_ctrl = 5'b11111; e_cls = 2'b10;
        end else if (hazard) begin
            e_ctrl = 5'b00011; e_cls = 2'b01;
        end else begin
            e_ctrl = 5'b11001; e_cls = 2'b00;
        end
    endfunction

    function automatic void model_advance();
        if (rst) begin
            m_ex.v = 1'b0; m_mem.v = 1'b0; m_wb.v = 1'b0;
            m_cnt = '0; m_state = 2'b00;
        end else begin
            m_state = e_cls;
            if (e_ctrl[0]) begin
                if (m_wb.v && m_wb.chk) m_cnt = m_cnt + 32'd1;
                m_wb = m_mem;
                m_mem = m_ex;
                m_ex = id_cur;
                m_ex.v = id_cur.v && !e_ctrl[1];
            end
        end
    endfunction

    task automatic put(input instr_t i, input logic tk, input logic rdy, input logic r);
        id_cur = i;
        rst = r;
        id_valid = i.v; id_rd = i.rd; id_rf_we = i.we; id_is_load = i.ld;
        id_is_mem = i.mem; id_num_check = i.chk; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use_rs = i.use_rs;
        ex_taken = tk;
        dmem_ready = rdy;
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic apply_reset();
        put(nop, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        put(nop, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ctrl !== 5'b00111) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 5'b00111); end
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); end
        tick();
        put(nop, 1'b0, 1'b1, 1'b0);
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
        n_checks++; if (num_inst !== 32'd0) begin n_fail++; $display("FAIL reset_num_inst: got %h want 0", num_inst); end
        n_checks++; if (ctrl !== 5'b11001) begin n_fail++; $display("FAIL reset_release_ctrl: got %b want %b", ctrl, 5'b11001); end
        tick();
    endtask

    task automatic test_load_use();
        instr_t lw, add;
        lw  = mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
        add = mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 2'b11);
        apply_reset();
        put(lw, 1'b0, 1'b1, 1'b0); tick();
        put(add, 1'b0, 1'b1, 1'b0);
        n_checks++; if (ctrl !== 5'b00011) begin n_fail++; $display("FAIL lu_stall_ctrl: got %b want %b", ctrl, 5'b00011); end
        tick();
        put(add, 1'b0, 1'b1, 1'b0);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL lu_state: got %b want 01", state); end
        n_checks++; if (ctrl !== 5'b11001) begin n_fail++; $display("FAIL lu_single_bubble: got %b want %b", ctrl, 5'b11001); end
        tick();
        put(nop, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({fwd_a, fwd_b} !== 4'b1000) begin n_fail++; $display("FAIL lu_fwd_wb: got %b want 1000", {fwd_a, fwd_b}); end
        tick();
    endtask

    task automatic test_back_to_back();
        instr_t prog [5];
        prog[0] = mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 2'b11);
        prog[1] = mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 2'b11);
        prog[2] = mk(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 2'b11);
        prog[3] = mk(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 2'b11);
        prog[4] = mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b11);
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            put((c < 5) ? prog[c] : nop, 1'b0, 1'b1, 1'b0);
            n_checks++; if ({ctrl, state} !== 7'b1100100) begin n_fail++; $display("FAIL b2b_no_stall c%0d: got %b want %b", c, {ctrl, state}, 7'b1100100); end
            if (c == 2) begin
                n_checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin n_fail++; $display("FAIL b2b_fwd_mem: got %b want 0101", {fwd_a, fwd_b}); end
            end
            if (c == 3) begin
                n_checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin n_fail++; $display("FAIL b2b_fwd_mix: got %b want 1001", {fwd_a, fwd_b}); end
            end
            if (c == 5) begin
                n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL b2b_fwd_x0: got %b want 0000", {fwd_a, fwd_b}); end
            end
            tick();
        end
    endtask

    task automatic test_flush_over_lu();
        instr_t lw, add;
        lw  = mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
        add = mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 2'b11);
        apply_reset();
        put(lw, 1'b0, 1'b1, 1'b0); tick();
        put(add, 1'b1, 1'b1, 1'b0);
        n_checks++; if (ctrl !== 5'b11111) begin n_fail++; $display("FAIL flush_ctrl: got %b want %b", ctrl, 5'b11111); end
        tick();
        put(nop, 1'b0, 1'b1, 1'b0);
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL flush_state: got %b want 10", state); end
        tick();
    endtask

    task automatic test_mwait();
        instr_t a1, lw2, a9;
        a1  = mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b00);
        lw2 = mk(1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        a9  = mk(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        apply_reset();
        put(a1, 1'b0, 1'b1, 1'b0); tick();
        put(lw2, 1'b0, 1'b1, 1'b0); tick();
        put(a9, 1'b0, 1'b1, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            put(nop, 1'b1, 1'b0, 1'b0);
            n_checks++; if (ctrl !== 5'b00000) begin n_fail++; $display("FAIL mwait_ctrl k%0d: got %b want 00000", k, ctrl); end
            n_checks++; if (num_inst !== 32'd0) begin n_fail++; $display("FAIL mwait_frozen k%0d: got %h want 0", k, num_inst); end
            if (k > 0) begin
                n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL mwait_state k%0d: got %b want 11", k, state); end
            end
            tick();
        end
        put(nop, 1'b1, 1'b1, 1'b0);
        n_checks++; if ({ctrl, state} !== 7'b1111111) begin n_fail++; $display("FAIL mwait_release: got %b want 1111111", {ctrl, state}); end
        tick();
        put(nop, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({state, num_inst} !== {2'b10, 32'd1}) begin n_fail++; $display("FAIL mwait_after: got %b/%h want 10/1", state, num_inst); end
        tick();
    endtask

    task automatic test_wrap();
        instr_t c7;
        c7 = mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b00);
        apply_reset();
        force dut.cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        for (int c = 0; c < 6; c++) begin
            put((c < 2) ? c7 : nop, 1'b0, 1'b1, 1'b0);
            if (c == 0) begin
                n_checks++; if (num_inst !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_preload: got %h want fffffffe", num_inst); end
            end
            if (c == 4) begin
                n_checks++; if (num_inst !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffffffff", num_inst); end
            end
            if (c == 5) begin
                n_checks++; if (num_inst !== 32'd0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", num_inst); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mwait();
        instr_t x10, a3, lw4, s8;
        x10 = mk(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b00);
        a3  = mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 2'b00);
        lw4 = mk(1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        s8  = mk(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 2'b01);
        apply_reset();
        put(x10, 1'b0, 1'b1, 1'b0); tick();
        put(a3, 1'b0, 1'b1, 1'b0); tick();
        put(lw4, 1'b0, 1'b1, 1'b0); tick();
        put(s8, 1'b0, 1'b1, 1'b0); tick();
        put(nop, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({ctrl, fwd_a} !== 7'b0000010) begin n_fail++; $display("FAIL rstmw_wait: got %b want 0000010", {ctrl, fwd_a}); end
        tick();
        put(nop, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({state, fwd_a, num_inst} !== {2'b11, 2'b10, 32'd1}) begin n_fail++; $display("FAIL rstmw_hold: got %b/%b/%h want 11/10/1", state, fwd_a, num_inst); end
        tick();
        put(nop, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({ctrl, fwd_a} !== 7'b0011100) begin n_fail++; $display("FAIL rstmw_in_reset: got %b want 0011100", {ctrl, fwd_a}); end
        tick();
        put(nop, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({state, fwd_a, num_inst} !== {2'b00, 2'b00, 32'd0}) begin n_fail++; $display("FAIL rstmw_after: got %b/%b/%h want 00/00/0", state, fwd_a, num_inst); end
        n_checks++; if (ctrl !== 5'b11001) begin n_fail++; $display("FAIL rstmw_run: got %b want 11001", ctrl); end
        tick();
    endtask

    task automatic test_random();
        instr_t i;
        logic tk, rdy, r;
        for (int n = 0; n < 800; n++) begin
            i.v      = 1'($urandom_range(0, 1));
            i.rd     = 5'($urandom_range(0, 3));
            i.ld     = ($urandom_range(0, 2) == 0);
            i.mem    = i.ld | ($urandom_range(0, 3) == 0);
            i.we     = i.ld | 1'($urandom_range(0, 1));
            i.chk    = 1'($urandom_range(0, 1));
            i.rs1    = 5'($urandom_range(0, 3));
            i.rs2    = 5'($urandom_range(0, 3));
            i.use_rs = 2'($urandom_range(0, 3));
            tk  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 59) == 0);
            put(i, tk, rdy, r);
            n_checks++; if (ctrl !== e_ctrl) begin n_fail++; $display("FAIL rand_ctrl n%0d: got %b want %b", n, ctrl, e_ctrl); end
            n_checks++; if ({fwd_a, fwd_b} !== {e_fwd_a, e_fwd_b}) begin n_fail++; $display("FAIL rand_fwd n%0d: got %b want %b", n, {fwd_a, fwd_b}, {e_fwd_a, e_fwd_b}); end
            n_checks++; if (state !== m_state) begin n_fail++; $display("FAIL rand_state n%0d: got %b want %b", n, state, m_state); end
            n_checks++; if (num_inst !== m_cnt) begin n_fail++; $display("FAIL rand_num_inst n%0d: got %h want %h", n, num_inst, m_cnt); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_flush_over_lu();
        test_mwait();
        test_wrap();
        test_reset_mwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
